bin_to_bcd_seq: RTL
===================

# bin_to_bcd_seq

Sequential binary-to-packed-BCD converter that produces the 7-digit, 28-bit packed BCD word consumed by the multiplexed seven-segment display driver. It accepts an unsigned binary value on a start/busy/done handshake, runs one shift-add-3 (double dabble) iteration per clock, and holds the result on a registered output until the next conversion completes. Inputs above the displayable range saturate to all nines and raise an overflow flag.

## Interface

Parameters:
- BIN_W, 24, width of binary input; one iteration per bit.
- DIGITS, 7, number of BCD digits; output width 4*DIGITS.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  BIN_W  unsigned binary value; sampled on the accepting edge only.
- bcd  out  4*DIGITS  packed BCD result; digit 0 (units) at [3:0], digit k at [4k+3:4k].
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd has just been updated.
- ovf  out  1  high when the last completed conversion saturated; valid with done and held until the next done.

## Operation

- States: IDLE, SHIFT.
- IDLE, start=1, bin <= 10^DIGITS-1: load the binary shift register with bin, clear the BCD scratch register, set iteration counter to 0, assert busy, and go to SHIFT.
- IDLE, start=1, bin > 10^DIGITS-1 (9,999,999 at defaults): no shift phase. On the same edge, set bcd to all digits 9, set ovf=1, and pulse done. State stays IDLE and busy stays 0.
- IDLE, start=0: hold all outputs; done=0.
- SHIFT, each cycle:
  - Add 3 to every scratch digit that is >= 5 (combinational, all digits in parallel).
  - Shift {scratch, binary} left by 1, with the binary MSB entering scratch bit 0.
  - Increment the counter.
- SHIFT, iteration with counter == BIN_W-1: on that edge, write the shifted scratch value into bcd, set ovf=0, pulse done, clear busy, and return to IDLE.
- start during SHIFT is ignored; no queuing.
- bin changes after acceptance have no effect.
- bcd, ovf: change only on a done edge; otherwise held.
- Arithmetic: the scratch register is 4*DIGITS bits and the counter is ceil(log2(BIN_W)) bits. Range gating guarantees that no digit exceeds 9 and that no carry leaves the top digit.
- Reset (rst=0 at a posedge, from any state, including mid-SHIFT):
  - state <= IDLE; busy <= 0; done <= 0; ovf <= 0; bcd <= 0.
  - The counter and scratch are cleared.
  - An in-flight conversion is discarded.

## Timing

- Accepting edge E: busy=1 is visible after E.
- Normal latency: done=1 and the new bcd are visible after edge E+BIN_W (24 cycles at defaults). busy falls on that same edge.
- Overflow latency: done=1, bcd=all 9s, and ovf=1 are visible after edge E; busy never rises.
- done is exactly one cycle wide. In the done cycle the block is IDLE, so start=1 in that cycle is accepted at the next edge (back-to-back). The maximum sustained rate is one result per BIN_W+1 cycles.
- The output is fully registered; there is no combinational path from start or bin to any output.

## Test plan

- Reset, then start with bin=0: busy is high for 24 cycles; done pulses with bcd=0x0000000 and ovf=0.
- bin=1234567 (0x12D687): done appears 24 cycles after acceptance with bcd=0x1234567. bin=9999999: bcd=0x9999999, ovf=0.
- bin=10000000: done appears 1 cycle after the start edge with bcd=0x9999999 and ovf=1; busy stays 0. A following bin=42 conversion gives bcd=0x0000042 and ovf=0.
- bin=500 accepted, then start=1 with bin=777 asserted on cycle 5 while busy: the result is bcd=0x0000500, there is exactly one done pulse, and 777 is never converted.
- bin=888888 accepted, rst=0 asserted on cycle 10: on the next edge busy=0, bcd=0, and ovf=0. No done pulse occurs; after release the block accepts a new start.
- Back-to-back: start held high continuously with bin=99, then 100. The second conversion is accepted in the cycle after the first done, and the done pulses are 25 cycles apart.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one bit per clock).
// Out-of-range inputs saturate to all nines in a single cycle and flag ovf.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 24,
    parameter int unsigned DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam int unsigned     BCD_W   = 4 * DIGITS;
    localparam int unsigned     CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0] NINES  = {DIGITS{4'h9}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;

    logic [BCD_W-1:0]   adj_c;
    logic [BCD_W-1:0]   scratch_d;
    logic               in_range_c;

    // Add 3 to every digit >= 5, then shift in the next binary MSB.
    always_comb begin
        adj_c = scratch_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (adj_c[4*k +: 4] >= 4'd5) begin
                adj_c[4*k +: 4] = adj_c[4*k +: 4] + 4'd3;
            end
        end
        scratch_d  = (adj_c << 1) | BCD_W'(bin_q[BIN_W-1]);
        in_range_c = (64'(bin) <= MAX_VAL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (in_range_c) begin
                            bin_q     <= bin;
                            scratch_q <= '0;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_SHIFT;
                        end else begin
                            bcd_q  <= NINES;
                            ovf_q  <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    scratch_q <= scratch_d;
                    bin_q     <= bin_q << 1;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        bcd_q   <= scratch_d;
                        ovf_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule
